// File: rtl/rv_mem_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency memory between the fetch and data ports
// of the rv_pl core, with data priority, a fetch starvation guard and a sticky done flag.
module rv_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4,
  parameter logic [AW-1:0] DONE_ADDR = AW'(32'h0000_2000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          done
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INST,
    RESP_DREAD
  } resp_t;

  resp_t         resp_q;
  logic [SW-1:0] streak_q;
  logic          done_q;
  logic          starve;

  // Handshake: a port's request (req plus its address/data) is held until the cycle its
  // gnt is high; that cycle is the transfer. Read data follows exactly one cycle later
  // with the port's rvalid, and a new grant may coincide with that rvalid.
  assign starve = i_req && (streak_q == STREAK_MAX);
  assign d_gnt  = rst_n && d_req && !starve;
  assign i_gnt  = rst_n && i_req && (!d_req || starve);

  assign m_en    = i_gnt || d_gnt;
  assign m_we    = d_gnt && d_we;
  assign m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign m_wdata = d_gnt ? d_wdata : '0;

  // Gating with rst_n drops a response whose grant landed just before reset asserted.
  assign i_rvalid = rst_n && (resp_q == RESP_INST);
  assign d_rvalid = rst_n && (resp_q == RESP_DREAD);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q   <= RESP_NONE;
      streak_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (i_gnt) begin
        resp_q <= RESP_INST;
      end else if (d_gnt && !d_we) begin
        resp_q <= RESP_DREAD;
      end else begin
        resp_q <= RESP_NONE;
      end

      // Counts data wins that kept a waiting fetch out; any fetch grant or idle fetch resets it.
      if (i_gnt || !i_req) begin
        streak_q <= '0;
      end else if (d_gnt && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + 1'b1;
      end

      if (d_gnt && d_we && (d_addr == DONE_ADDR)) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: a memory model behind the DUT, a cycle-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_rv_mem_arbiter;

  localparam int STARVE = 4;
  localparam logic [31:0] DONE_A = 32'h0000_2000;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        done;

  int n_vec;
  int n_miss;

  rv_mem_arbiter #(
    .AW(32), .DW(32), .STARVE_MAX(STARVE), .DONE_ADDR(DONE_A)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .done(done)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int k);
    case (k)
      0:       init_word = 32'd32;
      1:       init_word = 32'h0000_0011;
      2:       init_word = 32'hA5A5_0002;
      4:       init_word = 32'hDEAD_BEEF;
      default: init_word = {16'hC0DE, 16'(k)};
    endcase
  endfunction

  // Physical memory behind the arbiter: synchronous read, one cycle latency.
  logic [31:0] mem [0:4095];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 4096; k++) mem[k] <= init_word(k);
    end else if (m_en) begin
      if (m_we) mem[m_addr[13:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[13:2]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word-level memory image, how long fetch has been passed over,
  // the response owed next cycle (0 none, 1 fetch, 2 data read) and the done flag.
  logic [31:0] model_mem [0:4095];
  bit          model_loaded = 1'b0;
  int          m_wait;
  int          m_pend;
  logic [31:0] m_pdata;
  logic        m_done;

  always @(negedge clk) begin
    logic        e_ig, e_dg;
    logic [31:0] e_addr, e_wdata;
    if (!model_loaded) begin
      for (int k = 0; k < 4096; k++) model_mem[k] = init_word(k);
      m_wait = 0; m_pend = 0; m_pdata = '0; m_done = 1'b0;
      model_loaded = 1'b1;
    end
    if (!rst_n) begin
      e_ig = 1'b0;
      e_dg = 1'b0;
    end else begin
      e_ig = i_req && (!d_req || (m_wait >= STARVE));
      e_dg = d_req && !e_ig;
    end
    e_addr  = e_dg ? d_addr : (e_ig ? i_addr : 32'h0);
    e_wdata = e_dg ? d_wdata : 32'h0;
    check("i_gnt", i_gnt, e_ig);
    check("d_gnt", d_gnt, e_dg);
    check("m_en", m_en, e_ig || e_dg);
    check("m_we", m_we, e_dg && d_we);
    check("m_addr", m_addr, e_addr);
    check("m_wdata", m_wdata, e_wdata);
    check("i_rvalid", i_rvalid, rst_n && (m_pend == 1));
    check("d_rvalid", d_rvalid, rst_n && (m_pend == 2));
    if (rst_n && m_pend == 1) check("i_rdata", i_rdata, m_pdata);
    if (rst_n && m_pend == 2) check("d_rdata", d_rdata, m_pdata);
    check("done", done, m_done);

    if (!rst_n) begin
      m_wait = 0;
      m_pend = 0;
      m_done = 1'b0;
    end else begin
      if (e_ig) begin
        m_pend = 1; m_pdata = model_mem[i_addr[13:2]];
      end else if (e_dg && !d_we) begin
        m_pend = 2; m_pdata = model_mem[d_addr[13:2]];
      end else begin
        m_pend = 0;
      end
      if (e_dg && d_we) begin
        model_mem[d_addr[13:2]] = d_wdata;
        if (d_addr == DONE_A) m_done = 1'b1;
      end
      if (!i_req || e_ig) m_wait = 0;
      else if (e_dg && m_wait < STARVE) m_wait++;
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    logic [5:0] d_pat;
    logic       ig, dg;
    n_vec = 0;
    n_miss = 0;
    preload = 1'b1;
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    preload = 1'b0;
    @(negedge clk);
    check("reset_done", done, 1'b0);
    check("reset_i_gnt", i_gnt, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_i_rvalid", i_rvalid, 1'b0);
    next_cycle();

    // Single fetch from 0x10
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("t1_i_gnt", i_gnt, 1'b1);
    check("t1_m_addr", m_addr, 32'h10);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t1_i_rvalid", i_rvalid, 1'b1);
    check("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Simultaneous requests: data first, then fetch
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    @(negedge clk);
    check("t2_d_gnt", d_gnt, 1'b1);
    check("t2_i_gnt0", i_gnt, 1'b0);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("t2_i_gnt1", i_gnt, 1'b1);
    check("t2_d_rvalid", d_rvalid, 1'b1);
    check("t2_d_rdata", d_rdata, 32'd32);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t2_i_rvalid", i_rvalid, 1'b1);
    check("t2_i_rdata", i_rdata, 32'h11);
    next_cycle();

    // Starvation guard: fetch wins on the fifth contested cycle
    d_pat = 6'b101111;
    i_req = 1'b1; i_addr = 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t3_d_gnt_c%0d", c), d_gnt, d_pat[c]);
      check($sformatf("t3_i_gnt_c%0d", c), i_gnt, !d_pat[c]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Write to the completion address
    d_req = 1'b1; d_we = 1'b1; d_addr = DONE_A; d_wdata = 32'h1;
    @(negedge clk);
    check("t4_d_gnt", d_gnt, 1'b1);
    check("t4_m_we", m_we, 1'b1);
    check("t4_m_addr", m_addr, DONE_A);
    check("t4_done_before", done, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t4_done_set", done, 1'b1);
    check("t4_no_rvalid", d_rvalid, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("t4_done_held", done, 1'b1);
    next_cycle();

    // Reset right after a fetch grant drops the response
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("t5_i_gnt", i_gnt, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_i_rvalid", i_rvalid, 1'b0);
    check("t5_i_gnt_rst", i_gnt, 1'b0);
    check("t5_m_en_rst", m_en, 1'b0);
    next_cycle();
    @(negedge clk);
    check("t5_done_rst", done, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("t5_i_rvalid_after", i_rvalid, 1'b0);
    check("t5_done_after", done, 1'b0);
    next_cycle();

    // Write to a neighbouring address leaves done clear
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h5;
    @(negedge clk);
    check("t4b_d_gnt", d_gnt, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t4b_done", done, 1'b0);
    next_cycle();

    // Back-to-back fetches
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    check("t6_i_gnt0", i_gnt, 1'b1);
    next_cycle();
    i_addr = 32'h4;
    @(negedge clk);
    check("t6_i_gnt1", i_gnt, 1'b1);
    check("t6_i_rvalid1", i_rvalid, 1'b1);
    check("t6_i_rdata1", i_rdata, 32'd32);
    next_cycle();
    i_addr = 32'h8;
    @(negedge clk);
    check("t6_i_gnt2", i_gnt, 1'b1);
    check("t6_i_rdata2", i_rdata, 32'h11);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t6_i_rvalid3", i_rvalid, 1'b1);
    check("t6_i_rdata3", i_rdata, 32'hA5A5_0002);
    next_cycle();

    // Mixed traffic, requests held until granted; the model checks every cycle
    ig = 1'b0; dg = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (!i_req || ig) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_req || dg) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_addr  = ($urandom_range(0, 11) == 0) ? DONE_A : (32'($urandom_range(0, 15)) << 2);
      end
      @(negedge clk);
      ig = i_gnt;
      dg = d_gnt;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
